// File: rtl/alu_issue.sv
// RV32I ALU-op issue buffer. Each instruction is decoded when it is pushed, so the
// FIFO holds ready-to-use ALU operands, mode, rd and an illegal flag.
module alu_issue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_mode,
    output logic [4:0]  rd,
    output logic        illegal,
    output logic [15:0] illegal_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  mode;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [15:0]        ill_cnt_q, ill_cnt_d;

    logic               push, pop;
    entry_t             dec;
    entry_t             head;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [31:0]        imm_i;
    logic [31:0]        shamt;
    logic               legal;
    logic [2:0]         mode;
    logic [31:0]        op_b;
    logic               unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign shamt  = {27'b0, instr[24:20]};
    // Register indices for the source operands arrive already resolved in rs1/rs2_data.
    assign unused_rs1_field = ^instr[19:15];

    // The mode encoding matches funct3 for every base-form op, so only sub/sra need remapping.
    always_comb begin
        legal = 1'b0;
        mode  = 3'b000;
        op_b  = 32'b0;
        case (opcode)
            OPC_OP: begin
                op_b = rs2_data;
                if (funct7 == F7_ZERO && funct3 != 3'b010 && funct3 != 3'b011) begin
                    legal = 1'b1;
                    mode  = funct3;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    legal = 1'b1;
                    mode  = 3'b010;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    legal = 1'b1;
                    mode  = 3'b011;
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000, 3'b100, 3'b110, 3'b111: begin
                        legal = 1'b1;
                        mode  = funct3;
                        op_b  = imm_i;
                    end
                    3'b001: begin
                        op_b = shamt;
                        if (funct7 == F7_ZERO) begin
                            legal = 1'b1;
                            mode  = 3'b001;
                        end
                    end
                    3'b101: begin
                        op_b = shamt;
                        if (funct7 == F7_ZERO) begin
                            legal = 1'b1;
                            mode  = 3'b101;
                        end else if (funct7 == F7_ALT) begin
                            legal = 1'b1;
                            mode  = 3'b011;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec = '0;
        if (legal) begin
            dec.a    = rs1_data;
            dec.b    = op_b;
            dec.mode = mode;
            dec.rd   = instr[11:7];
            dec.ill  = 1'b0;
        end else begin
            dec.ill  = 1'b1;
        end
    end

    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        if (push && dec.ill && ill_cnt_q != 16'hFFFF) begin
            ill_cnt_d = ill_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Storage needs no reset: stale entries are never visible while count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign alu_a         = out_valid ? head.a    : 32'b0;
    assign alu_b         = out_valid ? head.b    : 32'b0;
    assign alu_mode      = out_valid ? head.mode : 3'b0;
    assign rd            = out_valid ? head.rd   : 5'b0;
    assign illegal       = out_valid ? head.ill  : 1'b0;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a reference decoder feeds a scoreboard queue at each push and
// the head entry is compared at each pop; scenario tasks add targeted inline checks.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_mode;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] illegal_count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  mode;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SLT = 32'h0020A1B3;

    alu_issue #(.DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_mode      (alu_mode),
        .rd            (rd),
        .illegal       (illegal),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: each supported instruction enumerated explicitly.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [31:0] imm;
        logic [31:0] sh;
        e   = '0;
        imm = {{20{ins[31]}}, ins[31:20]};
        sh  = {27'b0, ins[24:20]};
        e.ill = 1'b1;
        if (ins[6:0] == 7'h33) begin
            case ({ins[31:25], ins[14:12]})
                {7'h00, 3'd0}: begin e.ill = 0; e.mode = 3'd0; end
                {7'h00, 3'd1}: begin e.ill = 0; e.mode = 3'd1; end
                {7'h20, 3'd0}: begin e.ill = 0; e.mode = 3'd2; end
                {7'h20, 3'd5}: begin e.ill = 0; e.mode = 3'd3; end
                {7'h00, 3'd4}: begin e.ill = 0; e.mode = 3'd4; end
                {7'h00, 3'd5}: begin e.ill = 0; e.mode = 3'd5; end
                {7'h00, 3'd6}: begin e.ill = 0; e.mode = 3'd6; end
                {7'h00, 3'd7}: begin e.ill = 0; e.mode = 3'd7; end
                default:       e.ill = 1;
            endcase
            e.a = r1;
            e.b = r2;
        end else if (ins[6:0] == 7'h13) begin
            e.a = r1;
            case (ins[14:12])
                3'd0: begin e.ill = 0; e.mode = 3'd0; e.b = imm; end
                3'd4: begin e.ill = 0; e.mode = 3'd4; e.b = imm; end
                3'd6: begin e.ill = 0; e.mode = 3'd6; e.b = imm; end
                3'd7: begin e.ill = 0; e.mode = 3'd7; e.b = imm; end
                3'd1: begin e.ill = (ins[31:25] != 7'h00); e.mode = 3'd1; e.b = sh; end
                3'd5: begin
                    e.b = sh;
                    if (ins[31:25] == 7'h00) begin e.ill = 0; e.mode = 3'd5; end
                    else if (ins[31:25] == 7'h20) begin e.ill = 0; e.mode = 3'd3; end
                end
                default: e.ill = 1;
            endcase
        end
        if (e.ill) e = '0;
        else       e.rd = ins[11:7];
        e.ill = (e == '0) ? 1'b1 : e.ill;
        return e;
    endfunction

    // Scoreboard monitor: samples mid-cycle, pops before pushing to mirror FIFO order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL sb_pop: DUT popped a=%h with no expected entry queued", alu_a);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({alu_a, alu_b, alu_mode, rd, illegal} !== e) begin
                        n_miss++;
                        $display("FAIL sb_entry: got a=%h b=%h mode=%0d rd=%0d ill=%b, want a=%h b=%h mode=%0d rd=%0d ill=%b",
                                 alu_a, alu_b, alu_mode, rd, illegal, e.a, e.b, e.mode, e.rd, e.ill);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(instr, rs1_data, rs2_data));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_one(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        logic hs;
        int   cyc;
        instr = ins; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!hs && cyc < 50);
        in_valid = 1'b0;
        if (!hs) begin
            n_vec++; n_miss++;
            $display("FAIL push_timeout: instr %h not accepted within 50 cycles", ins);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs1_data = '0; rs2_data = '0;
        #2;
        n_vec++;
        if ({out_valid, in_ready, alu_a, alu_b, alu_mode, rd, illegal, illegal_count} !== {1'b0, 1'b1, 89'b0}) begin
            n_miss++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b a=%h b=%h cnt=%h, want 0 1 0 0 0",
                     out_valid, in_ready, alu_a, alu_b, illegal_count);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        instr = I_ADD; rs1_data = 32'h11; rs2_data = 32'h22; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || alu_b !== 32'h22) begin
            n_miss++;
            $display("FAIL first_push: out_valid=%b b=%h, want 1 00000022", out_valid, alu_b);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_decode;
        logic [31:0] tbl [12];
        tbl = '{32'h0020C1B3, 32'h002091B3, 32'h0020D1B3, 32'h4020D1B3, 32'h0020E1B3, 32'h0020F1B3,
                32'h0FF0E093, 32'h8000F093, 32'h00309093, 32'h01F0D093, 32'h7FF0C093, 32'h40008093};
        out_ready = 1'b1;
        push_one(I_ADD, 32'd5, 32'd7);
        n_vec++;
        if ({out_valid, alu_a, alu_b, alu_mode, rd, illegal} !== {1'b1, 32'd5, 32'd7, 3'd0, 5'd3, 1'b0}) begin
            n_miss++;
            $display("FAIL dec_add: v=%b a=%h b=%h mode=%0d rd=%0d ill=%b, want 1 5 7 0 3 0",
                     out_valid, alu_a, alu_b, alu_mode, rd, illegal);
        end
        push_one(32'h402081B3, 32'd9, 32'd4);
        n_vec++;
        if (alu_mode !== 3'd2) begin
            n_miss++; $display("FAIL dec_sub: mode=%0d want 2", alu_mode);
        end
        push_one(32'h40435293, 32'h80000000, 32'hDEADBEEF);
        n_vec++;
        if ({alu_mode, alu_b, rd} !== {3'd3, 32'd4, 5'd5}) begin
            n_miss++; $display("FAIL dec_srai: mode=%0d b=%h rd=%0d, want 3 4 5", alu_mode, alu_b, rd);
        end
        push_one(32'hFFF00093, 32'd0, 32'd1);
        n_vec++;
        if ({alu_mode, alu_b} !== {3'd0, 32'hFFFFFFFF}) begin
            n_miss++; $display("FAIL dec_addi: mode=%0d b=%h, want 0 ffffffff", alu_mode, alu_b);
        end
        for (int i = 0; i < 12; i++) push_one(tbl[i], 32'h1234_0000 + i, 32'hA5A5_0000 + i);
        @(posedge clk); #1;
    endtask

    task automatic test_illegal;
        logic [31:0] bad [6];
        bad = '{32'h022081B3, 32'h000011B7, 32'h0050A093, 32'h02009093, 32'h2000D093, 32'h4020C1B3};
        out_ready = 1'b1;
        push_one(I_SLT, 32'd5, 32'd7);
        n_vec++;
        if ({out_valid, illegal, alu_a, alu_b, alu_mode, rd, illegal_count} !== {2'b11, 72'b0, 16'd1}) begin
            n_miss++;
            $display("FAIL illegal_slt: ill=%b a=%h b=%h rd=%0d cnt=%0d, want 1 0 0 0 1",
                     illegal, alu_a, alu_b, rd, illegal_count);
        end
        for (int i = 0; i < 6; i++) push_one(bad[i], 32'hFFFF_FFFF, 32'h5555_5555);
        n_vec++;
        if (illegal_count !== 16'd7) begin
            n_miss++; $display("FAIL illegal_count: got %0d want 7", illegal_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        push_one(I_ADD, 32'hAAAA, 32'd1);
        push_one(I_ADD, 32'hBBBB, 32'd2);
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_miss++; $display("FAIL pre_reset_full: in_ready=%b out_valid=%b, want 0 1", in_ready, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({out_valid, in_ready, illegal_count, alu_a, rd} !== {1'b0, 1'b1, 16'd0, 32'd0, 5'd0}) begin
            n_miss++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b cnt=%0d a=%h, want 0 1 0 0",
                     out_valid, in_ready, illegal_count, alu_a);
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++; $display("FAIL reset_discard: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        push_one(I_ADD, 32'h100, 32'd0);
        push_one(I_ADD, 32'h200, 32'd0);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_miss++; $display("FAIL bp_full: in_ready=%b want 0", in_ready);
        end
        instr = I_ADD; rs1_data = 32'h300; rs2_data = 32'd0; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || alu_a !== 32'h100) begin
            n_miss++; $display("FAIL bp_hold: in_ready=%b a=%h, want 0 00000100", in_ready, alu_a);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_miss++; $display("FAIL full_pop_no_bypass: in_ready=%b want 0", in_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (in_ready !== 1'b1 || alu_a !== 32'h200) begin
            n_miss++; $display("FAIL bp_first_pop: in_ready=%b a=%h, want 1 00000200", in_ready, alu_a);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || alu_a !== 32'h300) begin
            n_miss++; $display("FAIL bp_held_accept: v=%b a=%h, want 1 00000300", out_valid, alu_a);
        end
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++; $display("FAIL bp_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        instr = I_ADD; rs1_data = 32'h1000; rs2_data = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            rs1_data = 32'h1000 + i;
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_a !== 32'h1000 + i) begin
                n_miss++;
                $display("FAIL b2b_%0d: v=%b rdy=%b a=%h, want 1 1 %h", i, out_valid, in_ready, alu_a, 32'h1000 + i);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturation;
        out_ready = 1'b1;
        instr = I_SLT; rs1_data = 32'd1; rs2_data = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk); #1;
            if (i == 65533) begin
                n_vec++;
                if (illegal_count !== 16'hFFFE) begin
                    n_miss++; $display("FAIL sat_pre: cnt=%h want fffe", illegal_count);
                end
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (illegal_count !== 16'hFFFF) begin
            n_miss++; $display("FAIL sat_reach: cnt=%h want ffff", illegal_count);
        end
        push_one(I_SLT, 32'd0, 32'd0);
        n_vec++;
        if (illegal_count !== 16'hFFFF) begin
            n_miss++; $display("FAIL sat_hold: cnt=%h want ffff", illegal_count);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++; $display("FAIL sb_leftover: %0d entries never popped, want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_mid_reset();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DEPTH, default 2, number of entries in the issue buffer; power of two, at least 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 in_valid  input  1  instruction word and operands are valid.
REQ-005 in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 rs1_data  input  32  value read for rs1.
REQ-008 rs2_data  input  32  value read for rs2.
REQ-009 out_valid  output  1  head entry is presented to the ALU.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 alu_a  output  32  ALU operand a.
REQ-012 alu_b  output  32  ALU operand b.
REQ-013 alu_mode  output  3  ALU mode: 000 add, 001 sll, 010 sub, 011 sra, 100 xor, 101 srl, 110 or, 111 and.
REQ-014 rd  output  5  destination register.
REQ-015 illegal  output  1  head entry is not a supported ALU op.
REQ-016 illegal_count  output  16  saturating count of illegal entries accepted.

Function
REQ-017 Handshake: push when in_valid && in_ready; pop when out_valid && out_ready; payload holds steady while out_valid && !out_ready.
REQ-018 Buffer: FIFO of DEPTH entries; in_ready = (count < DEPTH); out_valid = (count != 0); push and pop may occur in the same cycle, leaving count unchanged.
REQ-019 Latency: no combinational path from input to output; a push into an empty buffer appears on out_valid the next cycle.
REQ-020 Full plus pop: in_ready is 0 even when out_ready is 1; there is no same-cycle bypass.
REQ-021 Pointers: read and write pointers wrap modulo DEPTH.
REQ-022 Decode at push; the stored entry is {alu_a, alu_b, alu_mode, rd, illegal}.
REQ-023 OP (opcode 0110011): a = rs1_data, b = rs2_data.
  - funct7 0x00: funct3 000 add, 001 sll, 100 xor, 101 srl, 110 or, 111 and.
  - funct7 0x20: funct3 000 sub, 101 sra.
REQ-024 OP-IMM (opcode 0010011): a = rs1_data; b = sign-extended instr[31:20].
  - funct3 000 is add regardless of instr[30].
  - funct3 100, 110, 111 map to xor, or, and.
REQ-025 OP-IMM shifts: b = {27'b0, instr[24:20]}.
  - funct3 001 requires instr[31:25] = 0 (sll).
  - funct3 101 with instr[31:25] = 0x00 is srl; with 0x20 is sra.
REQ-026 Illegal cases: any other opcode; funct3 010/011 (slt/sltu/slti/sltiu); any unlisted funct7 combination.
  - Entry stores illegal = 1, a = 0, b = 0, mode = 000, rd = 0.
REQ-027 Legal entries store rd = instr[11:7] and illegal = 0.
REQ-028 illegal_count increments on each push with illegal decode and saturates at 0xFFFF.
REQ-029 When out_valid = 0, alu_a/alu_b/alu_mode/rd/illegal are driven to 0.

Reset
REQ-030 rst_n low clears count, both pointers and illegal_count immediately, regardless of clk.
  - out_valid = 0, in_ready = 1, all payload outputs = 0.
REQ-031 Reset mid-operation discards all buffered entries; no partial pop or push completes.
REQ-032 The first push is accepted on the first rising edge with rst_n high.

Verification
REQ-033 Decode/latency: push 0x002081B3 (add x3,x1,x2), rs1 = 5, rs2 = 7, out_ready = 1.
  - Next cycle: out_valid = 1, a = 5, b = 7, mode = 000, rd = 3, illegal = 0.
REQ-034 Sub and shift-immediate decode:
  - 0x402081B3 gives mode = 010.
  - 0x40435293 (srai x5,x6,4) gives mode = 011, b = 4, rd = 5.
  - 0xFFF00093 (addi x1,x0,-1) gives b = 0xFFFFFFFF, mode = 000.
REQ-035 Illegal: push 0x0020A1B3 (slt).
  - Response: illegal = 1, a = b = 0, rd = 0; illegal_count increments 0 to 1.
  - illegal_count stays 0xFFFF after saturation.
REQ-036 Full/backpressure: out_ready = 0, push 3 entries with DEPTH = 2.
  - in_ready drops after the second push; the third is held.
  - Raising out_ready drains entries in order; the held entry is accepted the cycle after the first pop.
REQ-037 Simultaneous push/pop at count = 1: count stays 1, order is preserved, and the pointer wrap is exercised over at least 2·DEPTH transfers.
REQ-038 Reset mid-stream: rst_n low with 2 entries buffered, asynchronous to clk.
  - Outputs go to out_valid = 0, in_ready = 1, illegal_count = 0 immediately.
